seq_scan_detect: RTL and testbench

- Sequencer and Moore detector sitting directly downstream of the pattern ROM (mem1).
- Walks the ROM address range, one address per clock, and consumes the returned serial bit.
- Runs the bit stream through a Moore FSM that recognises the pattern 1011.
- Reports detections, a saturating match count and scan completion to the control/test logic.

---
 rtl/seq_scan_detect.sv | 63 ++++++
 tb/tb_seq_scan_detect.sv | 126 ++++++++++++
 2 files changed

// File: rtl/seq_scan_detect.sv
// seq_scan_detect: steps the pattern ROM one address per clock and feeds each bit to a Moore 1011 detector.
// Define SEQ_OVERLAP_EN to let the tail of a match start the next one; by default matches never share bits.
module seq_scan_detect #(
    parameter int ADDR_W     = 10,
    parameter int FIRST_ADDR = 1,
    parameter int LAST_ADDR  = 21,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_data,
    output logic              busy,
    output logic              done,
    output logic              detect,
    output logic [2:0]        det_state,
    output logic [CNT_W-1:0]  match_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} scan_t;
    typedef enum logic [2:0] {S0, S1, S2, S3, S4} det_t;
    scan_t state, state_nx;
    det_t det, det_nx;
    logic launch, step, last;
    assign launch = state == IDLE && start;
    assign step   = state == RUN && !pause;
    assign last   = rom_addr == ADDR_W'(LAST_ADDR);
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_nx;
    always_comb
        state_nx = launch ? RUN : (step && last) ? FIN : (state == FIN) ? IDLE : state;
    always_comb begin
        busy = state == RUN;
        done = state == FIN;
        detect = det == S4;
        det_state = det;
    end
    // S0 and the non-overlapping S4 share the same exits, so they fall to the default
    always_comb begin
        det_nx = rom_data ? S1 : S0;
        case (det)
            S1: det_nx = rom_data ? S1 : S2;
            S2: det_nx = rom_data ? S3 : S0;
            S3: det_nx = rom_data ? S4 : S2;
`ifdef SEQ_OVERLAP_EN
            S4: det_nx = rom_data ? S1 : S2;
`endif
            default: ;
        endcase
    end
    always_ff @(posedge clk)
        if (rst || launch) begin
            rom_addr <= ADDR_W'(FIRST_ADDR);
            det <= S0;
            match_cnt <= '0;
        end else if (step) begin
            det <= det_nx;
            if (!last) rom_addr <= rom_addr + ADDR_W'(1);
            if (det_nx == S4 && !(&match_cnt)) match_cnt <= match_cnt + CNT_W'(1);
        end
endmodule

// File: tb/tb_seq_scan_detect.sv
// tb_seq_scan_detect: directed checks of the default scan, pause, reset, ignored starts and stub streams.
module tb_seq_scan_detect;
    logic clk = 0, rst = 1, pause = 0, s0 = 0, s1 = 0, s2 = 0;
    logic [9:0] a0, a1, a2;
    logic rd0, rd1, rd2, b0, b1, b2, dn0, dn1, dn2, dt0, dt1, dt2;
    logic [2:0] st0, st1, st2;
    logic [3:0] c0, c1;
    logic [0:0] c2;
    int n_chk = 0, n_fail = 0;
    localparam logic [1:21] R0 = 21'b100011000101101000100;
    localparam logic [1:7] R1 = 7'b1011011;
    localparam logic [1:8] R2 = 8'b10111011;
    always #5 clk = ~clk;
    assign rd0 = (a0 >= 1 && a0 <= 21) ? R0[a0] : 1'b0;
    assign rd1 = (a1 >= 1 && a1 <= 7) ? R1[a1] : 1'b0;
    assign rd2 = (a2 >= 1 && a2 <= 8) ? R2[a2] : 1'b0;
    seq_scan_detect u0 (.clk(clk), .rst(rst), .start(s0), .pause(pause), .rom_addr(a0), .rom_data(rd0),
        .busy(b0), .done(dn0), .detect(dt0), .det_state(st0), .match_cnt(c0));
    seq_scan_detect #(.LAST_ADDR(7)) u1 (.clk(clk), .rst(rst), .start(s1), .pause(1'b0), .rom_addr(a1),
        .rom_data(rd1), .busy(b1), .done(dn1), .detect(dt1), .det_state(st1), .match_cnt(c1));
    seq_scan_detect #(.LAST_ADDR(8), .CNT_W(1)) u2 (.clk(clk), .rst(rst), .start(s2), .pause(1'b0),
        .rom_addr(a2), .rom_data(rd2), .busy(b2), .done(dn2), .detect(dt2), .det_state(st2), .match_cnt(c2));
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    // p: pause in cycles 12-14; ig: extra starts in cycles 5 and 22 that must be ignored
    task automatic scan(input bit p, input bit ig);
        int sh;
        sh = p ? 3 : 0;
        s0 = 1;
        tick();
        s0 = 0;
        for (int c = 1; c <= 22 + sh; c++) begin
            pause = p && c >= 12 && c <= 14;
            s0 = ig && (c == 5 || c == 22);
            chk("addr", 32'(a0), (c <= 12) ? c : (p && c <= 15) ? 12 : (c - sh > 21) ? 21 : c - sh);
            chk("detect", 32'(dt0), 32'(c == 14 + sh));
            chk("done", 32'(dn0), 32'(c == 22 + sh));
            chk("busy", 32'(b0), 32'(c < 22 + sh));
            if (c == 14 + sh) chk("det_state_s4", 32'(st0), 4);
            if (c < 22 + sh) tick();
        end
        pause = 0;
        chk("cnt_end", 32'(c0), 1);
    endtask
    task automatic idle_chk();
        tick();
        chk("idle_busy", 32'(b0), 0);
        chk("idle_done", 32'(dn0), 0);
        chk("idle_cnt", 32'(c0), 1);
    endtask
    initial begin
        tick();
        tick();
        rst = 0;
        chk("rst_addr", 32'(a0), 1);
        chk("rst_busy", 32'(b0), 0);
        chk("rst_done", 32'(dn0), 0);
        chk("rst_state", 32'(st0), 0);
        chk("rst_cnt", 32'(c0), 0);
        scan(0, 0);
        idle_chk();
        scan(1, 0);
        idle_chk();
        scan(0, 1);
        tick();
        chk("fin_once", 32'(dn0), 0);
        chk("cnt_kept", 32'(c0), 1);
        tick();
        s0 = 0;
        chk("restart_busy", 32'(b0), 1);
        chk("restart_cnt", 32'(c0), 0);
        chk("restart_addr", 32'(a0), 1);
        repeat (9) tick();
        rst = 1;
        tick();
        rst = 0;
        chk("mid_rst_busy", 32'(b0), 0);
        chk("mid_rst_addr", 32'(a0), 1);
        chk("mid_rst_state", 32'(st0), 0);
        chk("mid_rst_cnt", 32'(c0), 0);
        chk("mid_rst_done", 32'(dn0), 0);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("no_done_after_rst", 32'(dn0), 0);
        end
        scan(0, 0);
        idle_chk();
        s1 = 1;
        s2 = 1;
        tick();
        s1 = 0;
        s2 = 0;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 8) begin
`ifdef SEQ_OVERLAP_EN
                chk("ov_detect", 32'(dt1), 32'(c == 5 || c == 8));
`else
                chk("ov_detect", 32'(dt1), 32'(c == 5));
`endif
                chk("ov_done", 32'(dn1), 32'(c == 8));
            end
            chk("sat_detect", 32'(dt2), 32'(c == 5 || c == 9));
            chk("sat_done", 32'(dn2), 32'(c == 9));
            chk("sat_cnt", 32'(c2), 32'(c >= 5));
            if (c == 8) begin
`ifdef SEQ_OVERLAP_EN
                chk("ov_cnt", 32'(c1), 2);
`else
                chk("ov_cnt", 32'(c1), 1);
`endif
            end
            if (c < 9) tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
